// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package hilo_muldiv_ctrl_pkg;

   // req_op encodings as decoded by EX
   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } muldiv_op_e;

   // Sequencer state encoding
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_MUL_WAIT = 2'd1;
   localparam logic [1:0] ST_DIV_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

   // LO value written for a division by zero (quotient of all ones)
   localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage.
// Accepts one MULT/MULTU/DIV/DIVU at a time, feeds the external pipelined
// multiplier and start/ready divider from registered operands, stalls the
// pipeline until the result exists and then issues a one-cycle HI/LO write.
// Optional build macro MULDIV_STATS_EN adds the stall_cycles counter output.
module hilo_muldiv_ctrl
   import hilo_muldiv_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [1:0]  req_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        annul,
   output logic        mul_signed,
   output logic [31:0] mul_opa,
   output logic [31:0] mul_opb,
   input  logic [63:0] mul_result,
   output logic        div_start,
   output logic        div_signed,
   output logic [31:0] div_opa,
   output logic [31:0] div_opb,
   input  logic        div_ready,
   input  logic [63:0] div_result,
   output logic        stallreq,
   output logic        busy,
`ifdef MULDIV_STATS_EN
   output logic [31:0] stall_cycles,
`endif
   output logic        hilo_we,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam logic [2:0] CNT_INIT = 3'(MUL_LAT);

   logic [1:0]  r_state;
   logic [2:0]  r_cnt;
   logic [31:0] r_opa;
   logic [31:0] r_opb;
   logic        r_signed;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic [1:0]  w_state_nxt;
   logic [2:0]  w_cnt_nxt;
   logic [31:0] w_opa_nxt;
   logic [31:0] w_opb_nxt;
   logic        w_signed_nxt;
   logic [31:0] w_hi_nxt;
   logic [31:0] w_lo_nxt;

   // Next-state: annul abandons whatever is in flight, otherwise walk the FSM
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_opa_nxt    = r_opa;
      w_opb_nxt    = r_opb;
      w_signed_nxt = r_signed;
      w_hi_nxt     = r_hi;
      w_lo_nxt     = r_lo;
      if (annul) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  w_opa_nxt    = src_a;
                  w_opb_nxt    = src_b;
                  w_signed_nxt = op_is_signed(req_op);
                  if (!op_is_div(req_op)) begin
                     w_state_nxt = ST_MUL_WAIT;
                     w_cnt_nxt   = CNT_INIT;
                  end else if (src_b == 32'd0) begin
                     // Divide by zero is resolved here; the divider never starts
                     w_hi_nxt    = src_a;
                     w_lo_nxt    = DIV0_LO;
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_state_nxt = ST_DIV_RUN;
                  end
               end
            end
            ST_MUL_WAIT: begin
               w_cnt_nxt = r_cnt - 3'd1;
               if (r_cnt == 3'd1) begin
                  {w_hi_nxt, w_lo_nxt} = mul_result;
                  w_state_nxt          = ST_DONE;
               end
            end
            ST_DIV_RUN: begin
               if (div_ready) begin
                  // Divider returns {remainder, quotient} = {HI, LO}
                  w_hi_nxt    = div_result[63:32];
                  w_lo_nxt    = div_result[31:0];
                  w_state_nxt = ST_DONE;
               end
            end
            ST_DONE: begin
               w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State, counter, operand and result registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 3'd0;
         r_opa    <= 32'd0;
         r_opb    <= 32'd0;
         r_signed <= 1'b0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_opa    <= w_opa_nxt;
         r_opb    <= w_opb_nxt;
         r_signed <= w_signed_nxt;
         r_hi     <= w_hi_nxt;
         r_lo     <= w_lo_nxt;
      end
   end

   // Stall while an op is being accepted or is still producing its result
   always_comb begin
      stallreq = 1'b0;
      case (r_state)
         ST_IDLE:     stallreq = req_valid & ~annul;
         ST_MUL_WAIT: stallreq = 1'b1;
         ST_DIV_RUN:  stallreq = 1'b1;
         default:     stallreq = 1'b0;
      endcase
   end

   // Divider start is a level held through DIV_RUN, dropped on ready or annul
   always_comb begin
      div_start = (r_state == ST_DIV_RUN) & ~div_ready & ~annul;
      hilo_we   = (r_state == ST_DONE) & ~annul;
      busy      = (r_state != ST_IDLE);
   end

   assign mul_signed = r_signed;
   assign mul_opa    = r_opa;
   assign mul_opb    = r_opb;
   assign div_signed = r_signed;
   assign div_opa    = r_opa;
   assign div_opb    = r_opb;
   assign hi_o       = r_hi;
   assign lo_o       = r_lo;

`ifdef MULDIV_STATS_EN
   logic [31:0] r_stall_cycles;

   // Saturating count of stalled cycles; only rst clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= 32'd0;
      end else if (stallreq && (r_stall_cycles != 32'hFFFF_FFFF)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed cases then random ops
// against an arithmetic reference, with behavioural multiplier/divider cores.
module tb_hilo_muldiv_ctrl;

   localparam int unsigned MUL_LAT = 2;

   localparam logic [1:0] T_MULT  = 2'b00;
   localparam logic [1:0] T_MULTU = 2'b01;
   localparam logic [1:0] T_DIV   = 2'b10;
   localparam logic [1:0] T_DIVU  = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        annul;
   logic        mul_signed;
   logic [31:0] mul_opa;
   logic [31:0] mul_opb;
   logic [63:0] mul_result;
   logic        div_start;
   logic        div_signed;
   logic [31:0] div_opa;
   logic [31:0] div_opb;
   logic        div_ready;
   logic [63:0] div_result;
   logic        stallreq;
   logic        busy;
   logic        hilo_we;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
`ifdef MULDIV_STATS_EN
   logic [31:0] stall_cycles;
   int          m_stall_cnt = 0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   hilo_muldiv_ctrl #(
      .MUL_LAT(MUL_LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .src_a      (src_a),
      .src_b      (src_b),
      .annul      (annul),
      .mul_signed (mul_signed),
      .mul_opa    (mul_opa),
      .mul_opb    (mul_opb),
      .mul_result (mul_result),
      .div_start  (div_start),
      .div_signed (div_signed),
      .div_opa    (div_opa),
      .div_opb    (div_opb),
      .div_ready  (div_ready),
      .div_result (div_result),
      .stallreq   (stallreq),
      .busy       (busy),
`ifdef MULDIV_STATS_EN
      .stall_cycles (stall_cycles),
`endif
      .hilo_we    (hilo_we),
      .hi_o       (hi_o),
      .lo_o       (lo_o)
   );

   always #5 clk = ~clk;

   // Reference arithmetic: full 64-bit product, {remainder, quotient} for divide
   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
      logic [63:0] ea;
      logic [63:0] eb;
      ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
      eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
      return ea * eb;
   endfunction

   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
      longint la;
      longint lb;
      longint q;
      longint r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
         la = longint'($signed(a));
         lb = longint'($signed(b));
      end else begin
         la = longint'({32'd0, a});
         lb = longint'({32'd0, b});
      end
      q = la / lb;
      r = la % lb;
      return {r[31:0], q[31:0]};
   endfunction

   // Multiplier core: one register stage, result usable in the last MUL_WAIT cycle.
   // Divider core: ready once start has been held for g_dlat cycles; junk otherwise.
   int          g_dlat = 1;
   int          r_dcnt = 0;
   logic [63:0] r_mprod = 64'd0;
   logic [63:0] r_junk = 64'd0;

   always @(posedge clk) begin
      r_junk  <= {$urandom, $urandom};
      r_mprod <= ref_mul(mul_opa, mul_opb, mul_signed);
      if (rst || !div_start) r_dcnt <= 0;
      else r_dcnt <= r_dcnt + 1;
`ifdef MULDIV_STATS_EN
      if (rst) m_stall_cnt <= 0;
      else if (stallreq) m_stall_cnt <= m_stall_cnt + 1;
`endif
   end

   assign mul_result = r_mprod;
   assign div_ready  = (r_dcnt == g_dlat);
   always_comb div_result = div_ready ? ref_div(div_opa, div_opb, div_signed) : r_junk;

   // One instruction: abort_kind 0 none, 1 annul, 2 rst at cycle abort_k after acceptance.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int dlat, input int abort_kind, input int abort_k,
                         input bit tail);
      bit          is_div;
      bit          sgn;
      logic [63:0] expv;
      int          done;
      is_div = op[1];
      sgn    = ~op[0];
      expv   = is_div ? ref_div(a, b, sgn) : ref_mul(a, b, sgn);
      done   = !is_div ? 1 + MUL_LAT : ((b == 32'd0) ? 1 : dlat + 2);
      g_dlat = dlat;
      @(posedge clk);
      #1;
      for (int k = 0; k <= done; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         req_valid = 1'b1;
         annul     = (abort_kind == 1) && (k == abort_k);
         rst       = (abort_kind == 2) && (k == abort_k);
         if (k == 0) begin
            req_op = op;
            src_a  = a;
            src_b  = b;
         end else begin
            // EX inputs wander after acceptance; only the registered copies matter
            req_op = 2'($urandom_range(0, 3));
            src_a  = $urandom;
            src_b  = $urandom;
         end
         #1;
         if ((abort_kind != 0) && (k == abort_k)) begin
            if (abort_kind == 1) begin
               chk("annul_hilo_we", hilo_we, 1'b0);
               chk("annul_div_start", div_start, 1'b0);
               if (k == 0) chk("annul_idle_stall", stallreq, 1'b0);
            end
            break;
         end
         chk("stallreq", stallreq, (k < done));
         chk("hilo_we", hilo_we, (k == done));
         chk("busy", busy, (k > 0));
         chk("div_start", div_start, (is_div && (b != 32'd0) && (k >= 1) && (k <= done - 2)));
         if (k == done) begin
            chk("hi_o", hi_o, expv[63:32]);
            chk("lo_o", lo_o, expv[31:0]);
            if (!is_div) chk("mul_signed", mul_signed, sgn);
            else if (b != 32'd0) chk("div_signed", div_signed, sgn);
         end
      end
      if (abort_kind != 0) begin
         @(posedge clk);
         #1;
         rst       = 1'b0;
         annul     = 1'b0;
         req_valid = 1'b0;
         #1;
         chk("abort_busy", busy, 1'b0);
         chk("abort_hilo_we", hilo_we, 1'b0);
         chk("abort_stallreq", stallreq, 1'b0);
         chk("abort_div_start", div_start, 1'b0);
         if (abort_kind == 2) begin
            chk("rst_hi_o", hi_o, 32'd0);
            chk("rst_lo_o", lo_o, 32'd0);
            chk("rst_mul_opa", mul_opa, 32'd0);
            chk("rst_mul_opb", mul_opb, 32'd0);
            chk("rst_div_opa", div_opa, 32'd0);
            chk("rst_div_opb", div_opb, 32'd0);
            chk("rst_mul_signed", mul_signed, 1'b0);
         end
      end else if (tail) begin
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         #1;
         chk("tail_busy", busy, 1'b0);
         chk("tail_hilo_we", hilo_we, 1'b0);
         chk("tail_stallreq", stallreq, 1'b0);
      end
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          dlat;
      int          d;
      int          ab;
      int          ak;

      rst       = 1'b1;
      req_valid = 1'b0;
      annul     = 1'b0;
      req_op    = 2'b00;
      src_a     = 32'd0;
      src_b     = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("reset_stallreq", stallreq, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_hilo_we", hilo_we, 1'b0);
      chk("reset_div_start", div_start, 1'b0);
      chk("reset_hi_o", hi_o, 32'd0);
      chk("reset_lo_o", lo_o, 32'd0);
      chk("reset_mul_opa", mul_opa, 32'd0);
      chk("reset_div_opb", div_opb, 32'd0);

      // MULT -3 * 5
      run_op(T_MULT, 32'hFFFF_FFFD, 32'd5, 1, 0, 0, 1'b1);
      // DIVU 100 / 7 with a slow divider
      run_op(T_DIVU, 32'd100, 32'd7, 33, 0, 0, 1'b1);
      // DIV by zero
      run_op(T_DIV, 32'd5, 32'd0, 1, 0, 0, 1'b1);
      // DIV -7 / 2 annulled in the 4th DIV_RUN cycle, then MULTU 3 * 4
      run_op(T_DIV, 32'hFFFF_FFF9, 32'd2, 33, 1, 4, 1'b0);
      run_op(T_MULTU, 32'd3, 32'd4, 1, 0, 0, 1'b1);
      // Reset while waiting on the multiplier
      run_op(T_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1, 2, 1, 1'b0);
      // Back-to-back MULTU 2 * 3 then DIV -8 / 3
      run_op(T_MULTU, 32'd2, 32'd3, 1, 0, 0, 1'b0);
      run_op(T_DIV, 32'hFFFF_FFF8, 32'd3, 5, 0, 0, 1'b1);
      // annul coinciding with div_ready discards the result
      run_op(T_DIVU, 32'd50, 32'd5, 3, 1, 4, 1'b1);
      // Signed overflow corner
      run_op(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2, 0, 0, 1'b1);

      for (int i = 0; i < 40; i++) begin
         op   = 2'($urandom_range(0, 3));
         a    = $urandom;
         b    = ($urandom_range(0, 5) == 0) ? 32'd0 :
                (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : $urandom);
         dlat = $urandom_range(1, 40);
         d    = !op[1] ? 1 + MUL_LAT : ((b == 32'd0) ? 1 : dlat + 2);
         ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
         ak   = $urandom_range(0, d);
         run_op(op, a, b, dlat, ab, ak, 1'($urandom_range(0, 1)));
      end

      @(posedge clk);
      #1;
      req_valid = 1'b0;
      #1;
`ifdef MULDIV_STATS_EN
      chk("stall_cycles", stall_cycles, 32'(m_stall_cnt));
`endif
      chk("final_busy", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
